// File: rtl/itr_sequencer.sv
// Interrupt entry/exit sequencer for the accumulator CPU: waits for an instruction
// boundary, saves PC/ACC, vectors to the ISR, and restores on RETI or watchdog timeout.
module itr_sequencer #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int WDOG_MAX = 200
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          i_pending,
  input  logic [AW-1:0] vec_addr,
  input  logic [1:0]    src_code,
  input  logic          instr_done,
  input  logic          ei,
  input  logic          di,
  input  logic          reti,
  input  logic [AW-1:0] pc_in,
  input  logic [DW-1:0] acc_in,
  output logic          itr_en,
  output logic          itr_clr,
  output logic          pc_load,
  output logic [AW-1:0] pc_out,
  output logic          acc_load,
  output logic [DW-1:0] acc_out,
  output logic          stall,
  output logic          in_isr,
  output logic [1:0]    active_src,
  output logic          wdog_err
);

  localparam int CW = (WDOG_MAX > 2) ? $clog2(WDOG_MAX) : 1;
  localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_VECTOR,
    S_SERVICE,
    S_RESTORE
  } state_t;

  state_t          state_q, state_d;
  logic            gie_q;
  logic [AW-1:0]   save_pc_q;
  logic [DW-1:0]   save_acc_q;
  logic [AW-1:0]   save_vec_q;
  logic [1:0]      save_src_q;
  logic [CW-1:0]   wdog_cnt_q;
  logic            wdog_err_q;

  logic wdog_hit;
  logic take_irq;
  logic gie_ctl;

  assign wdog_hit = (wdog_cnt_q == WDOG_LAST);
  assign take_irq = (state_q == S_ARM) && i_pending && gie_q && instr_done;
  assign gie_ctl  = (state_q == S_IDLE) || (state_q == S_ARM);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned
  // (that would infer a latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (gie_q && i_pending) state_d = S_ARM;
      S_ARM: begin
        if (!i_pending || !gie_q) state_d = S_IDLE;
        else if (instr_done)      state_d = S_VECTOR;
      end
      S_VECTOR:  state_d = S_SERVICE;
      S_SERVICE: if (reti || wdog_hit) state_d = S_RESTORE;
      S_RESTORE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      gie_q      <= 1'b0;
      save_pc_q  <= '0;
      save_acc_q <= '0;
      save_vec_q <= '0;
      save_src_q <= '0;
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (gie_ctl) begin
        if (di)      gie_q <= 1'b0;
        else if (ei) gie_q <= 1'b1;
      end else if (state_q == S_VECTOR) begin
        gie_q <= 1'b0;
      end else if (state_q == S_RESTORE) begin
        gie_q <= 1'b1;
      end

      if (take_irq) begin
        save_pc_q  <= pc_in;
        save_acc_q <= acc_in;
        save_vec_q <= vec_addr;
        save_src_q <= src_code;
      end

      // A coincident reti takes priority, so the timeout only flags when reti is absent.
      if (state_q == S_SERVICE) begin
        if (!reti && wdog_hit) wdog_err_q <= 1'b1;
        if (!wdog_hit)         wdog_cnt_q <= wdog_cnt_q + 1'b1;
      end else if (state_q == S_RESTORE) begin
        wdog_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    itr_en     = gie_q && gie_ctl;
    itr_clr    = 1'b0;
    pc_load    = 1'b0;
    pc_out     = '0;
    acc_load   = 1'b0;
    acc_out    = '0;
    stall      = 1'b0;
    in_isr     = 1'b0;
    active_src = '0;
    wdog_err   = wdog_err_q;
    case (state_q)
      S_VECTOR: begin
        itr_clr = 1'b1;
        pc_load = 1'b1;
        pc_out  = save_vec_q;
        stall   = 1'b1;
      end
      S_SERVICE: begin
        in_isr     = 1'b1;
        active_src = save_src_q;
      end
      S_RESTORE: begin
        pc_load  = 1'b1;
        pc_out   = save_pc_q;
        acc_load = 1'b1;
        acc_out  = save_acc_q;
        stall    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
